// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with DONE hold/ACK handshake.
// Optional macro BIN2BCD_SIGNED_EN: treat BIN as two's complement, report sign on NEG.
module bin2bcd_seq #(
    parameter int WIDTH     = 16,
    parameter int DIGITS    = 5,
    parameter int DONE_HOLD = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  INIT,
    input  logic                  ACK,
    input  logic [WIDTH-1:0]      BIN,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  NEG,
    output logic                  BUSY,
    output logic                  DONE
);

    // True when DIGITS decimal digits can hold every WIDTH-bit magnitude.
    function automatic bit digits_ok(input int w, input int d);
        logic [63:0] p;
        if (d >= 11) return 1'b1;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p > (64'd1 << w);
    endfunction

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be in 2..32");
    end
    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small, need 10^DIGITS > 2^WIDTH");
    end
    if (DONE_HOLD < 1 || DONE_HOLD > 255) begin : g_bad_hold
        $error("bin2bcd_seq: DONE_HOLD must be in 1..255");
    end

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_INIT  = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [7:0]      HOLD_LAST = 8'(DONE_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADJ,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       sr;
    logic [4*DIGITS-1:0]    acc;
    logic [4*DIGITS-1:0]    acc_adj;
    logic [4*DIGITS-1:0]    acc_shifted;
    logic [CW-1:0]          bitcnt;
    logic [7:0]             holdcnt;
    logic [WIDTH-1:0]       operand;
    logic                   start;
    logic                   finish;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // INIT is honoured only in S_IDLE and S_FIN, and beats ACK in S_FIN.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (INIT) begin
                    start     = 1'b1;
                    state_nxt = S_ADJ;
                end
            end
            S_ADJ: begin
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (bitcnt == CNT_ONE) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_ADJ;
                end
            end
            S_FIN: begin
                if (INIT) begin
                    start     = 1'b1;
                    state_nxt = S_ADJ;
                end else if (ACK || holdcnt == HOLD_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign finish = (state == S_SHIFT) && (bitcnt == CNT_ONE);
    assign BUSY   = (state == S_ADJ) || (state == S_SHIFT);
    assign DONE   = (state == S_FIN);

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign acc_shifted = {acc[4*DIGITS-2:0], sr[WIDTH-1]};

    // The final step is a shift, so the published result is the shifted accumulator.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr      <= '0;
            acc     <= '0;
            bitcnt  <= '0;
            holdcnt <= '0;
            BCD     <= '0;
        end else begin
            if (start) begin
                sr     <= operand;
                acc    <= '0;
                bitcnt <= CNT_INIT;
            end else begin
                case (state)
                    S_ADJ: begin
                        acc <= acc_adj;
                    end
                    S_SHIFT: begin
                        acc    <= acc_shifted;
                        sr     <= {sr[WIDTH-2:0], 1'b0};
                        bitcnt <= bitcnt - CNT_ONE;
                    end
                    default: begin
                    end
                endcase
            end

            if (finish) begin
                BCD <= acc_shifted;
            end

            if (state == S_FIN && !start) begin
                holdcnt <= holdcnt + 8'd1;
            end else begin
                holdcnt <= '0;
            end
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic sign_q;

    // The most negative value negates to itself, which read unsigned is its magnitude.
    assign operand = BIN[WIDTH-1] ? (~BIN + ONE) : BIN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sign_q <= 1'b0;
            NEG    <= 1'b0;
        end else begin
            if (start) begin
                sign_q <= BIN[WIDTH-1];
            end
            if (finish) begin
                NEG <= sign_q;
            end
        end
    end
`else
    assign operand = BIN;
    assign NEG     = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq at WIDTH=16, DIGITS=5, DONE_HOLD=32.
// Latency is counted in cycles from the cycle INIT is presented (accept edge = cycle 1).
module tb_bin2bcd_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INIT;
    logic        ACK;
    logic [15:0] BIN;
    logic [19:0] BCD;
    logic        NEG;
    logic        BUSY;
    logic        DONE;

    int testsRun    = 0;
    int testsFailed = 0;

`ifdef BIN2BCD_SIGNED_EN
    localparam logic SIGNED_BUILD = 1'b1;
`else
    localparam logic SIGNED_BUILD = 1'b0;
`endif

    bin2bcd_seq #(
        .WIDTH    (16),
        .DIGITS   (5),
        .DONE_HOLD(32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .INIT(INIT),
        .ACK (ACK),
        .BIN (BIN),
        .BCD (BCD),
        .NEG (NEG),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents INIT for one cycle, then counts cycles until DONE (bounded).
    task automatic run_conversion(input logic [15:0] value, output int cycles);
        @(negedge CLK);
        BIN  = value;
        INIT = 1'b1;
        @(posedge CLK);
        #1;
        INIT   = 1'b0;
        cycles = 1;
        while (DONE !== 1'b1 && cycles < 200) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
    endtask

    task automatic pulse_ack();
        @(negedge CLK);
        ACK = 1'b1;
        @(posedge CLK);
        #1;
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST  = 1'b1;
        INIT = 1'b0;
        ACK  = 1'b0;
        BIN  = '0;
        #12;
        testsRun++;
        if (BCD !== 20'h00000) begin testsFailed++; $display("[TB] FAIL reset_bcd: got %h expected %h", BCD, 20'h00000); end
        testsRun++;
        if (NEG !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_neg: got %b expected 0", NEG); end
        testsRun++;
        if (BUSY !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
        testsRun++;
        if (DONE !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_zero();
        int c;
        run_conversion(16'd0, c);
        testsRun++;
        if (c !== 33) begin testsFailed++; $display("[TB] FAIL zero_latency: got %0d expected 33", c); end
        testsRun++;
        if (BCD !== 20'h00000) begin testsFailed++; $display("[TB] FAIL zero_bcd: got %h expected %h", BCD, 20'h00000); end
        testsRun++;
        if (NEG !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_neg: got %b expected 0", NEG); end
        testsRun++;
        if (BUSY !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_busy_in_fin: got %b expected 0", BUSY); end
        pulse_ack();
        testsRun++;
        if (DONE !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_ack_done: got %b expected 0", DONE); end
    endtask

    task automatic test_result_hold();
        int   c;
        logic held;
        logic sawBusy;
        run_conversion(16'd65535, c);
        testsRun++;
        if (BCD !== 20'h65535) begin testsFailed++; $display("[TB] FAIL max_bcd: got %h expected %h", BCD, 20'h65535); end
        pulse_ack();

        @(negedge CLK);
        BIN  = 16'd12345;
        INIT = 1'b1;
        @(posedge CLK);
        #1;
        INIT    = 1'b0;
        c       = 1;
        held    = 1'b1;
        sawBusy = 1'b0;
        while (DONE !== 1'b1 && c < 200) begin
            if (BUSY === 1'b1) sawBusy = 1'b1;
            if (BCD !== 20'h65535) held = 1'b0;
            @(posedge CLK);
            #1;
            c++;
        end
        testsRun++;
        if (held !== 1'b1 || sawBusy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL hold_during_busy: got held=%b busy=%b expected held=1 busy=1", held, sawBusy);
        end
        testsRun++;
        if (c !== 33) begin testsFailed++; $display("[TB] FAIL second_latency: got %0d expected 33", c); end
        testsRun++;
        if (BCD !== 20'h12345) begin testsFailed++; $display("[TB] FAIL second_bcd: got %h expected %h", BCD, 20'h12345); end
        pulse_ack();
    endtask

    task automatic test_busy_init_and_hold_expiry();
        int c;
        int hold;
        @(negedge CLK);
        BIN  = 16'd4321;
        INIT = 1'b1;
        @(posedge CLK);
        #1;
        INIT = 1'b0;
        BIN  = 16'd999;
        c    = 1;
        while (DONE !== 1'b1 && c < 200) begin
            INIT = (c == 5 || c == 20);
            ACK  = (c == 12);
            @(posedge CLK);
            #1;
            c++;
        end
        INIT = 1'b0;
        ACK  = 1'b0;
        testsRun++;
        if (c !== 33) begin testsFailed++; $display("[TB] FAIL busy_init_latency: got %0d expected 33", c); end
        testsRun++;
        if (BCD !== 20'h04321) begin testsFailed++; $display("[TB] FAIL busy_init_bcd: got %h expected %h", BCD, 20'h04321); end

        hold = 0;
        while (DONE === 1'b1 && hold < 100) begin
            hold++;
            @(posedge CLK);
            #1;
        end
        testsRun++;
        if (hold !== 32) begin testsFailed++; $display("[TB] FAIL hold_expiry_cycles: got %0d expected 32", hold); end
        testsRun++;
        if (BCD !== 20'h04321 || BUSY !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL after_expiry: got bcd=%h busy=%b expected bcd=04321 busy=0", BCD, BUSY);
        end
    endtask

    task automatic test_ack_early();
        int   c;
        logic doneThird;
        run_conversion(16'd7, c);
        testsRun++;
        if (BCD !== 20'h00007) begin testsFailed++; $display("[TB] FAIL ack_bcd: got %h expected %h", BCD, 20'h00007); end
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        doneThird = DONE;
        ACK = 1'b1;
        @(posedge CLK);
        #1;
        ACK = 1'b0;
        testsRun++;
        if (doneThird !== 1'b1) begin testsFailed++; $display("[TB] FAIL ack_third_cycle_done: got %b expected 1", doneThird); end
        testsRun++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ack_release: got done=%b busy=%b expected done=0 busy=0", DONE, BUSY);
        end
        @(posedge CLK);
        #1;
        testsRun++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ack_idle: got done=%b busy=%b expected done=0 busy=0", DONE, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        run_conversion(16'd100, c);
        testsRun++;
        if (BCD !== 20'h00100) begin testsFailed++; $display("[TB] FAIL b2b_first_bcd: got %h expected %h", BCD, 20'h00100); end
        BIN  = 16'd9876;
        INIT = 1'b1;
        ACK  = 1'b1;
        @(posedge CLK);
        #1;
        INIT = 1'b0;
        ACK  = 1'b0;
        c    = 1;
        testsRun++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_init_priority: got done=%b busy=%b expected done=0 busy=1", DONE, BUSY);
        end
        while (DONE !== 1'b1 && c < 200) begin
            @(posedge CLK);
            #1;
            c++;
        end
        testsRun++;
        if (c !== 33) begin testsFailed++; $display("[TB] FAIL b2b_latency: got %0d expected 33", c); end
        testsRun++;
        if (BCD !== 20'h09876) begin testsFailed++; $display("[TB] FAIL b2b_bcd: got %h expected %h", BCD, 20'h09876); end
    endtask

    task automatic test_reset_mid();
        int c;
        @(negedge CLK);
        BIN  = 16'd54321;
        INIT = 1'b1;
        @(posedge CLK);
        #1;
        INIT = 1'b0;
        repeat (9) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        testsRun++;
        if (BCD !== 20'h00000 || BUSY !== 1'b0 || DONE !== 1'b0 || NEG !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: got bcd=%h busy=%b done=%b neg=%b expected all zero", BCD, BUSY, DONE, NEG);
        end
        @(negedge CLK);
        RST = 1'b0;
        run_conversion(16'd54321, c);
        testsRun++;
        if (c !== 33) begin testsFailed++; $display("[TB] FAIL post_reset_latency: got %0d expected 33", c); end
        testsRun++;
        if (BCD !== 20'h54321) begin testsFailed++; $display("[TB] FAIL post_reset_bcd: got %h expected %h", BCD, 20'h54321); end
        pulse_ack();
    endtask

    task automatic test_signed();
        int c;
        run_conversion(16'h8000, c);
        testsRun++;
        if (BCD !== 20'h32768 || NEG !== SIGNED_BUILD) begin
            testsFailed++;
            $display("[TB] FAIL sign_8000: got bcd=%h neg=%b expected bcd=32768 neg=%b", BCD, NEG, SIGNED_BUILD);
        end
        pulse_ack();
        run_conversion(16'hFFFF, c);
        testsRun++;
        if (SIGNED_BUILD) begin
            if (BCD !== 20'h00001 || NEG !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL sign_ffff: got bcd=%h neg=%b expected bcd=00001 neg=1", BCD, NEG);
            end
        end else begin
            if (BCD !== 20'h65535 || NEG !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL sign_ffff: got bcd=%h neg=%b expected bcd=65535 neg=0", BCD, NEG);
            end
        end
        pulse_ack();
        run_conversion(16'd42, c);
        testsRun++;
        if (BCD !== 20'h00042 || NEG !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sign_positive: got bcd=%h neg=%b expected bcd=00042 neg=0", BCD, NEG);
        end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_result_hold();
        test_busy_init_and_hold_expiry();
        test_ack_early();
        test_back_to_back();
        test_reset_mid();
        test_signed();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
